pcie_send_dispatcher: RTL and testbench
=======================================

Name: pcie_send_dispatcher

Overview:
- Sits between the PCIe-side send control (6-bit RAM slot plus a signal line) and the two TSE MAC send-packet controllers (25-bit DDR start address plus a cmd_send pulse).
- Edge-detects PCIe send requests and queues their slot numbers in a small FIFO.
- Translates each slot to a DDR byte/word address and dispatches it round-robin to send channel 1 or 2.
- Enforces a per-channel hold-off after each command and gates all dispatch on MAC initialisation.

Parameters:
- FIFO_AW, 3: log2 of queue depth (depth 8).
- SLOT_SHIFT, 10: left shift applied to the slot number to form the DDR address.
- BASE_ADDR, 25'h0000000: DDR address offset added to the shifted slot.
- HOLDOFF, 64: cycles a channel stays blocked after a cmd_send. Range 1..65535.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- mac_inited  in  1  high once both MACs are configured; gates dispatch.
- pcie_start_ram_addr  in  6  slot number, valid on the rising edge of pcie_signal.
- pcie_signal  in  1  send request, level; the rising edge is the event.
- send1_start_ram_addr  out  25  DDR start address for channel 1.
- send1_cmd_send  out  1  one-cycle command pulse, channel 1.
- send2_start_ram_addr  out  25  DDR start address for channel 2.
- send2_cmd_send  out  1  one-cycle command pulse, channel 2.
- fifo_level  out  FIFO_AW+1  current queue occupancy.
- overflow  out  1  sticky: a request was dropped.
- drop_count  out  16  number of dropped requests, saturating.

Behaviour:
- Reset (synchronous, dominant over all other events): every output is 0; the FIFO is emptied; pcie_signal_d=0; both hold-off counters=0; rr_ptr=channel 1. Entries pending at reset are discarded and nothing is emitted for them.
- Edge detect: pcie_signal_d registers pcie_signal. push = pcie_signal & ~pcie_signal_d. pcie_start_ram_addr is sampled in the push cycle. A level held high produces exactly one push.
- Push accept rule: accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the request is dropped: overflow is set (sticky until reset) and drop_count increments, saturating at 16'hFFFF.
  - Simultaneous push and pop leaves count unchanged.
- Address computation: addr = (BASE_ADDR + ({19'b0,slot} << SLOT_SHIFT)) mod 2^25, computed at pop time.
- Channel free: a channel is free when its hold-off counter equals 0. Issuing to a channel loads HOLDOFF into its counter. Each counter decrements by 1 per cycle while nonzero and keeps running regardless of mac_inited.
- Dispatch FSM, two states:
  - IDLE: if FIFO non-empty and mac_inited=1 and at least one channel is free, pop the head and go to ISSUE in the same cycle.
  - Channel choice: take rr_ptr if its channel is free, otherwise take the other channel. Set rr_ptr to the opposite of the channel used.
  - ISSUE: the registered outputs for the chosen channel take the address and cmd_send=1 for this one cycle; then return to IDLE.
- Latency and throughput:
  - Push in cycle N → earliest pop in N+1 → cmd_send visible in N+2.
  - Maximum rate is one dispatch per 2 cycles.
- Output stability: sendX_start_ram_addr updates only in a cycle where sendX_cmd_send=1 and holds its value afterwards. cmd_send never asserts on both channels in the same cycle.
- mac_inited=0: pushes are still accepted and no pops occur. If mac_inited falls while in ISSUE, the pulse in progress completes.
- fifo_level reflects count after the current cycle's push and pop (registered).

Test Plan:
1. Reset release, mac_inited=1, single pcie_signal rising edge with slot=6'h05, BASE=0, SHIFT=10 → exactly 2 cycles later send1_cmd_send=1 for 1 cycle with send1_start_ram_addr=25'h0001400; send2 stays idle.
2. Three edges spaced 4 cycles apart, slots 1, 2, 3, HOLDOFF=64 → dispatched to ch1, ch2, then held until ch1's counter expires (64 cycles after the first issue); ch1 then gets addr 25'h0000C00.
3. mac_inited=0, 10 request edges, depth 8 → fifo_level=8, overflow=1, drop_count=2, no cmd_send. Then raise mac_inited → 8 commands emitted in FIFO order, alternating channels as hold-off allows.
4. pcie_signal held high for 20 cycles → exactly one push and one command.
5. Push and pop in the same cycle while full → fifo_level stays 8, overflow remains 0.
6. Assert reset with 5 entries queued and ch2 in hold-off → all outputs 0 the next cycle, fifo_level=0, no cmd_send after release until a new edge arrives.

Source files
------------

// File: rtl/pcie_send_dispatcher.sv
// Queues PCIe send requests by RAM slot and dispatches them as DDR start addresses
// to two TSE MAC send channels, round-robin, with a per-channel hold-off after each command.
module pcie_send_dispatcher #(
   parameter int          FIFO_AW    = 3,
   parameter int          SLOT_SHIFT = 10,
   parameter logic [24:0] BASE_ADDR  = 25'h0000000,
   parameter int          HOLDOFF    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mac_inited,
   input  logic [5:0]        pcie_start_ram_addr,
   input  logic              pcie_signal,
   output logic [24:0]       send1_start_ram_addr,
   output logic              send1_cmd_send,
   output logic [24:0]       send2_start_ram_addr,
   output logic              send2_cmd_send,
   output logic [FIFO_AW:0]  fifo_level,
   output logic              overflow,
   output logic [15:0]       drop_count
);

   localparam int               DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t             state_q, state_d;
   logic               sig_q;
   logic [5:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic [15:0]        hold1_q, hold1_d, hold2_q, hold2_d;
   logic               rr_q, rr_d;           // 0 = channel 1 preferred, 1 = channel 2
   logic [24:0]        addr1_q, addr1_d, addr2_q, addr2_d;
   logic               cmd1_q, cmd1_d, cmd2_q, cmd2_d;
   logic               overflow_q;
   logic [15:0]        drop_cnt_q;

   logic               push, push_ok, pop, drop, use2, free1, free2;
   logic [24:0]        head_addr;

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      push      = pcie_signal & ~sig_q;
      free1     = (hold1_q == 16'd0);
      free2     = (hold2_q == 16'd0);
      head_addr = BASE_ADDR + (25'(mem_q[rd_ptr_q]) << SLOT_SHIFT);
      pop       = 1'b0;
      use2      = 1'b0;
      state_d   = state_q;
      rr_d      = rr_q;
      cmd1_d    = 1'b0;
      cmd2_d    = 1'b0;
      addr1_d   = addr1_q;
      addr2_d   = addr2_q;
      hold1_d   = free1 ? hold1_q : hold1_q - 16'd1;
      hold2_d   = free2 ? hold2_q : hold2_q - 16'd1;

      case (state_q)
         S_IDLE: begin
            if ((count_q != '0) && mac_inited && (free1 || free2)) begin
               pop     = 1'b1;
               use2    = rr_q ? free2 : ~free1;
               rr_d    = ~use2;
               state_d = S_ISSUE;
               if (use2) begin
                  cmd2_d  = 1'b1;
                  addr2_d = head_addr;
                  hold2_d = 16'(HOLDOFF);
               end else begin
                  cmd1_d  = 1'b1;
                  addr1_d = head_addr;
                  hold1_d = 16'(HOLDOFF);
               end
            end
         end
         S_ISSUE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A full queue still takes a request when the head leaves in the same cycle.
      push_ok = push & ((count_q != DEPTH_C) | pop);
      drop    = push & ~push_ok;
      count_d = count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
   end

   // NOTE: the queue storage has no reset; pointers and count define validity,
   // and leaving the array unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= pcie_start_ram_addr;
   end

   // NOTE: state registers use non-blocking assignment so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sig_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         hold1_q    <= '0;
         hold2_q    <= '0;
         rr_q       <= 1'b0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         cmd1_q     <= 1'b0;
         cmd2_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         sig_q   <= pcie_signal;
         count_q <= count_d;
         hold1_q <= hold1_d;
         hold2_q <= hold2_d;
         rr_q    <= rr_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         cmd1_q  <= cmd1_d;
         cmd2_q  <= cmd2_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign send1_start_ram_addr = addr1_q;
   assign send1_cmd_send       = cmd1_q;
   assign send2_start_ram_addr = addr2_q;
   assign send2_cmd_send       = cmd2_q;
   assign fifo_level           = count_q;
   assign overflow             = overflow_q;
   assign drop_count           = drop_cnt_q;

endmodule

// File: tb/tb_pcie_send_dispatcher.sv
// Directed bench for pcie_send_dispatcher: a vector table of single requests plus
// hand-written sequences for hold-off, overflow, held level, full push/pop and reset.
module tb_pcie_send_dispatcher;

   localparam int HOLDOFF = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mac_inited = 1'b0;
   logic [5:0]  pcie_start_ram_addr = '0;
   logic        pcie_signal = 1'b0;
   logic [24:0] send1_start_ram_addr, send2_start_ram_addr;
   logic        send1_cmd_send, send2_cmd_send;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      int          ch;
      logic [24:0] addr;
   } ev_t;
   ev_t ev_q[$];

   typedef struct {
      logic [5:0]  slot;
      int          exp_ch;
      logic [24:0] exp_addr;
   } vec_t;
   vec_t vecs[5];

   pcie_send_dispatcher #(
      .FIFO_AW(3), .SLOT_SHIFT(10), .BASE_ADDR(25'h0000000), .HOLDOFF(HOLDOFF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mac_inited(mac_inited),
      .pcie_start_ram_addr(pcie_start_ram_addr),
      .pcie_signal(pcie_signal),
      .send1_start_ram_addr(send1_start_ram_addr),
      .send1_cmd_send(send1_cmd_send),
      .send2_start_ram_addr(send2_start_ram_addr),
      .send2_cmd_send(send2_cmd_send),
      .fifo_level(fifo_level),
      .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Command pulse log, sampled mid-cycle.
   always @(negedge clk) begin
      check("no_dual_cmd", {31'd0, send1_cmd_send & send2_cmd_send}, 32'd0);
      if (send1_cmd_send === 1'b1) ev_q.push_back('{cyc, 1, send1_start_ram_addr});
      if (send2_cmd_send === 1'b1) ev_q.push_back('{cyc, 2, send2_start_ram_addr});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic req(input logic [5:0] slot, output int n);
      pcie_start_ram_addr = slot;
      pcie_signal         = 1'b1;
      n                   = cyc;
      tick();
      pcie_signal = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      pcie_signal = 1'b0;
      mac_inited  = 1'b0;
      tick();
      check("rst_cmd1",  {31'd0, send1_cmd_send}, 32'd0);
      check("rst_cmd2",  {31'd0, send2_cmd_send}, 32'd0);
      check("rst_addr1", {7'd0, send1_start_ram_addr}, 32'd0);
      check("rst_addr2", {7'd0, send2_start_ram_addr}, 32'd0);
      check("rst_level", {28'd0, fifo_level}, 32'd0);
      check("rst_ovf",   {31'd0, overflow}, 32'd0);
      check("rst_drops", {16'd0, drop_count}, 32'd0);
      tick();
      reset = 1'b0;
      ev_q.delete();
   endtask

   initial begin
      int n, n1;

      vecs[0] = '{6'h05, 1, 25'h0001400};
      vecs[1] = '{6'h00, 2, 25'h0000000};
      vecs[2] = '{6'h3F, 1, 25'h000FC00};
      vecs[3] = '{6'h20, 2, 25'h0008000};
      vecs[4] = '{6'h15, 1, 25'h0005400};

      // Single requests spaced past the hold-off; channels alternate from ch1.
      do_reset();
      mac_inited = 1'b1;
      tick();
      for (int v = 0; v < 5; v++) begin
         ev_q.delete();
         req(vecs[v].slot, n);
         ticks(HOLDOFF + 6);
         check($sformatf("vec%0d_count", v), ev_q.size(), 1);
         if (ev_q.size() == 1) begin
            check($sformatf("vec%0d_cyc", v), ev_q[0].cyc, n + 2);
            check($sformatf("vec%0d_ch", v), ev_q[0].ch, vecs[v].exp_ch);
            check($sformatf("vec%0d_addr", v), {7'd0, ev_q[0].addr}, {7'd0, vecs[v].exp_addr});
         end
         check($sformatf("vec%0d_hold", v),
               {7'd0, (vecs[v].exp_ch == 1) ? send1_start_ram_addr : send2_start_ram_addr},
               {7'd0, vecs[v].exp_addr});
      end

      // Three requests 4 cycles apart: ch1, ch2, then ch1 once its hold-off expires.
      do_reset();
      mac_inited = 1'b1;
      tick();
      req(6'd1, n1);
      ticks(2);
      req(6'd2, n);
      ticks(2);
      req(6'd3, n);
      ticks(HOLDOFF + 20);
      check("ho_count", ev_q.size(), 3);
      if (ev_q.size() == 3) begin
         check("ho_ch0", ev_q[0].ch, 1);
         check("ho_cyc0", ev_q[0].cyc, n1 + 2);
         check("ho_ch1", ev_q[1].ch, 2);
         check("ho_cyc1", ev_q[1].cyc, n1 + 6);
         check("ho_ch2", ev_q[2].ch, 1);
         check("ho_cyc2", ev_q[2].cyc, n1 + 2 + HOLDOFF + 1);
         check("ho_addr2", {7'd0, ev_q[2].addr}, 32'h0000C00);
      end

      // Ten requests while the MACs are down: eight queued, two dropped.
      do_reset();
      for (int i = 0; i < 10; i++) req(6'(10 + i), n);
      check("ovf_level", {28'd0, fifo_level}, 32'd8);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_drops", {16'd0, drop_count}, 32'd2);
      check("ovf_nocmd", ev_q.size(), 0);
      mac_inited = 1'b1;
      ticks(400);
      check("drain_count", ev_q.size(), 8);
      for (int i = 0; i < 8 && i < ev_q.size(); i++) begin
         check($sformatf("drain%0d_addr", i), {7'd0, ev_q[i].addr}, (10 + i) << 10);
         check($sformatf("drain%0d_ch", i), ev_q[i].ch, (i % 2) + 1);
      end
      check("drain_level", {28'd0, fifo_level}, 32'd0);

      // A level held high is one request.
      do_reset();
      mac_inited          = 1'b1;
      pcie_start_ram_addr = 6'h07;
      pcie_signal         = 1'b1;
      ticks(20);
      pcie_signal = 1'b0;
      ticks(HOLDOFF + 10);
      check("level_count", ev_q.size(), 1);
      if (ev_q.size() == 1) check("level_addr", {7'd0, ev_q[0].addr}, 32'h0001C00);

      // Push and pop in the same cycle while full.
      do_reset();
      for (int i = 0; i < 8; i++) req(6'(i), n);
      check("full_level", {28'd0, fifo_level}, 32'd8);
      mac_inited          = 1'b1;
      pcie_start_ram_addr = 6'h3F;
      pcie_signal         = 1'b1;
      tick();
      pcie_signal = 1'b0;
      check("pp_level", {28'd0, fifo_level}, 32'd8);
      check("pp_ovf", {31'd0, overflow}, 32'd0);
      check("pp_drops", {16'd0, drop_count}, 32'd0);
      ticks(400);
      check("pp_count", ev_q.size(), 9);
      if (ev_q.size() == 9) begin
         check("pp_first", {7'd0, ev_q[0].addr}, 32'h0000000);
         check("pp_last", {7'd0, ev_q[8].addr}, 32'h000FC00);
      end

      // Reset with entries pending and both channels in hold-off.
      do_reset();
      mac_inited = 1'b1;
      tick();
      req(6'd1, n);
      req(6'd2, n);
      for (int i = 0; i < 5; i++) req(6'(20 + i), n);
      check("pre_rst_level", {28'd0, fifo_level}, 32'd5);
      check("pre_rst_cmds", ev_q.size(), 2);
      do_reset();
      mac_inited = 1'b1;
      ticks(20);
      check("post_rst_quiet", ev_q.size(), 0);
      req(6'd9, n);
      ticks(6);
      check("post_rst_count", ev_q.size(), 1);
      if (ev_q.size() == 1) begin
         check("post_rst_cyc", ev_q[0].cyc, n + 2);
         check("post_rst_ch", ev_q[0].ch, 1);
         check("post_rst_addr", {7'd0, ev_q[0].addr}, 32'h0002400);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
